// File: rtl/moravec_ff.sv
// One stage of the Moravec corner-response chain: registers min(incoming score,
// saturated squared center/neighbour difference) and forwards the start token.
module moravec_ff #(
   parameter int PIXEL_WIDTH = 8,
   parameter int E_WIDTH     = 14
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [PIXEL_WIDTH-1:0] inCenter,
   input  logic [PIXEL_WIDTH-1:0] inTarget,
   input  logic [E_WIDTH-1:0]     inE,
   output logic                   Q,
   output logic [E_WIDTH-1:0]     Eout
);

   localparam int SW = 2 * PIXEL_WIDTH;

   logic [PIXEL_WIDTH-1:0] diff;
   logic [SW-1:0]          sq;
   logic [E_WIDTH-1:0]     sat;
   logic [E_WIDTH-1:0]     cand;

   always_comb begin
      diff = (inCenter >= inTarget) ? (inCenter - inTarget) : (inTarget - inCenter);
      sq   = SW'(diff) * SW'(diff);
   end

   // Clamp only when the square can exceed the score path.
   generate
      if (SW > E_WIDTH) begin : g_sat
         always_comb sat = (|sq[SW-1:E_WIDTH]) ? '1 : sq[E_WIDTH-1:0];
      end else begin : g_nosat
         always_comb sat = E_WIDTH'(sq);
      end
   endgenerate

   always_comb cand = (inE < sat) ? inE : sat;

   // start is a level: Q follows it every edge; Eout only loads while it is high
   // so the final score stays put after the chain drains.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Q    <= 1'b0;
         Eout <= '0;
      end else begin
         Q <= start;
         if (start) Eout <= cand;
      end
   end

endmodule

// File: tb/tb_moravec_ff.sv
// Directed and random checks of one moravec_ff stage plus a four-stage chain,
// with expected results queued at drive time and popped at sample time.
module tb_moravec_ff;

   localparam int PW = 8;
   localparam int EW = 14;
   localparam int W  = 18;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // ---------------- single stage ----------------
   logic          start;
   logic [PW-1:0] center, target;
   logic [EW-1:0] in_e;
   logic          q;
   logic [EW-1:0] eout;

   moravec_ff #(.PIXEL_WIDTH(PW), .E_WIDTH(EW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .inCenter(center), .inTarget(target), .inE(in_e),
      .Q(q), .Eout(eout)
   );

   // ---------------- four-stage chain ----------------
   logic          chain_start;
   logic [PW-1:0] chain_center;
   logic [PW-1:0] chain_target [4];
   logic [EW-1:0] chain_e0;
   logic          cq [4];
   logic [EW-1:0] ce [4];

   for (genvar g = 0; g < 4; g++) begin : g_chain
      moravec_ff #(.PIXEL_WIDTH(PW), .E_WIDTH(EW)) stage (
         .clk(clk), .rst_n(rst_n),
         .start   ((g == 0) ? chain_start : cq[(g == 0) ? 0 : g-1]),
         .inCenter(chain_center),
         .inTarget(chain_target[g]),
         .inE     ((g == 0) ? chain_e0 : ce[(g == 0) ? 0 : g-1]),
         .Q(cq[g]), .Eout(ce[g])
      );
   end

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   int n_cmp  = 0;
   int n_fail = 0;

   function automatic logic [EW-1:0] model(input int c, input int t, input int e);
      int d, s, m;
      d = (c > t) ? c - t : t - c;
      s = d * d;
      if (s > 16383) s = 16383;
      m = (e < s) ? e : s;
      return EW'(m);
   endfunction

   task automatic expect_single(input logic exp_q_bit, input logic [EW-1:0] exp_e);
      exp_q.push_back({3'b000, exp_q_bit, exp_e});
   endtask

   task automatic check(input string tag, input logic [W-1:0] obs);
      logic [W-1:0] exp_v;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $error("FAIL %s: observed %h but scoreboard empty", tag, obs);
      end else begin
         exp_v = exp_q.pop_front();
         assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
         end
      end
   endtask

   task automatic check_single(input string tag);
      check(tag, {3'b000, q, eout});
   endtask

   task automatic check_chain(input string tag);
      check(tag, {cq[3], cq[2], cq[1], cq[0], ce[3]});
   endtask

   // ---------------- driver ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s, input int c, input int t, input int e);
      start  = s;
      center = PW'(c);
      target = PW'(t);
      in_e   = EW'(e);
   endtask

   task automatic run_chain(input int t2, input logic [EW-1:0] final_e);
      chain_center    = 8'd50;
      chain_target[0] = 8'd60;
      chain_target[1] = PW'(t2);
      chain_target[2] = 8'd80;
      chain_target[3] = 8'd52;
      chain_e0        = 14'd10000;
      chain_start     = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         step();
         // Q rises one stage per edge; final score only checked on edge 4.
         if (k < 4) begin
            exp_q.push_back({4'((1 << k) - 1), ce[3]});
            check_chain($sformatf("chain_edge%0d", k));
         end else begin
            exp_q.push_back({4'b1111, final_e});
            check_chain("chain_final");
         end
      end
      chain_start = 1'b0;
      repeat (5) step();
      exp_q.push_back({4'b0000, final_e});
      check_chain("chain_drained_hold");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [EW-1:0] model_e;
      int c, t, e;
      logic s;

      rst_n       = 1'b0;
      chain_start = 1'b0;
      chain_center = '0;
      for (int i = 0; i < 4; i++) chain_target[i] = '0;
      chain_e0    = '0;
      drive(1'b1, 100, 90, 10000);

      // Reset held across edges with start high.
      step(); step();
      expect_single(1'b0, 14'd0);
      check_single("reset_held");
      exp_q.push_back({4'b0000, 14'd0});
      check_chain("chain_reset_held");

      rst_n = 1'b1;
      step();
      expect_single(1'b1, 14'd100);
      check_single("first_edge_after_reset");

      // Asynchronous reset mid-cycle, no clock edge in between.
      #3 rst_n = 1'b0;
      #1;
      expect_single(1'b0, 14'd0);
      check_single("async_reset_immediate");
      step();
      expect_single(1'b0, 14'd0);
      check_single("async_reset_edge_held");
      rst_n = 1'b1;

      drive(1'b1, 100, 90, 10000); step();
      expect_single(1'b1, 14'd100); check_single("basic_100_90");
      drive(1'b1, 90, 100, 10000); step();
      expect_single(1'b1, 14'd100); check_single("basic_swapped");
      drive(1'b1, 10, 200, 10000); step();
      expect_single(1'b1, 14'd10000); check_single("min_takes_inE");
      drive(1'b1, 10, 200, 16383); step();
      expect_single(1'b1, 14'd16383); check_single("sat_inE_max");
      drive(1'b1, 0, 128, 16383); step();
      expect_single(1'b1, 14'd16383); check_single("sat_d128");
      drive(1'b1, 0, 127, 16383); step();
      expect_single(1'b1, 14'd16129); check_single("d127_no_sat");
      drive(1'b1, 255, 0, 16383); step();
      expect_single(1'b1, 14'd16383); check_single("sat_d255");
      drive(1'b1, 55, 55, 10000); step();
      expect_single(1'b1, 14'd0); check_single("zero_diff");
      drive(1'b1, 100, 90, 0); step();
      expect_single(1'b1, 14'd0); check_single("inE_zero");
      drive(1'b1, 100, 90, 57); step();
      expect_single(1'b1, 14'd57); check_single("inE_small");

      // Hold: start low, inputs changing, Eout frozen at 100.
      drive(1'b1, 100, 90, 10000); step();
      expect_single(1'b1, 14'd100); check_single("hold_setup");
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 16383));
         step();
         expect_single(1'b0, 14'd100);
         check_single($sformatf("hold_cycle%0d", i));
      end

      // Random start/data against the bench model.
      model_e = 14'd100;
      for (int i = 0; i < 40; i++) begin
         s = ($urandom_range(0, 3) != 0);
         c = $urandom_range(0, 255);
         t = $urandom_range(0, 255);
         e = (i % 4 == 0) ? 16383 : $urandom_range(0, 16383);
         drive(s, c, t, e);
         if (s) model_e = model(c, t, e);
         step();
         expect_single(s, model_e);
         check_single($sformatf("random%0d", i));
      end
      drive(1'b0, 0, 0, 0);

      // Chain: fresh reset, then two runs.
      rst_n = 1'b0; #2; rst_n = 1'b1;
      run_chain(45, 14'd4);
      run_chain(50, 14'd0);

      // Reset mid-chain: nothing stale appears afterwards.
      chain_target[1] = 8'd45;
      chain_start = 1'b1;
      step(); step();
      #2 rst_n = 1'b0;
      chain_start = 1'b0;
      #1;
      exp_q.push_back({4'b0000, 14'd0});
      check_chain("chain_midreset_clear");
      rst_n = 1'b1;
      repeat (4) begin
         step();
         exp_q.push_back({4'b0000, 14'd0});
         check_chain("chain_no_stale_token");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/moravec_ff.md
# moravec_ff

Single pipeline stage of the Moravec corner-response chain. Each stage registers the squared intensity difference between a window's center pixel and one neighbour, and keeps the running minimum of that difference and the incoming score. It forwards a start/valid token one cycle later. `kernelRam` instantiates four chains of four stages, one chain per shift direction; a non-zero final score from a chain marks the center pixel as a corner candidate.

## Interface
Parameters:
- `PIXEL_WIDTH`, default 8: width of `inCenter` and `inTarget`.
- `E_WIDTH`, default 14: width of the score path `inE` / `Eout`.

Ports:
- `clk`, input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n`, input, 1 bit: asynchronous, active-low reset.
- `start`, input, 1 bit: stage enable / token in. Driven by the previous stage's `Q`, or by `detectCorner` for stage 1.
- `inCenter`, input, `PIXEL_WIDTH` bits: unsigned center pixel value.
- `inTarget`, input, `PIXEL_WIDTH` bits: unsigned neighbour pixel value.
- `inE`, input, `E_WIDTH` bits: unsigned incoming score. The first stage of each chain is fed 10000.
- `Q`, output, 1 bit: registered token out.
- `Eout`, output, `E_WIDTH` bits: registered score out.

## Operation
- Combinational difference: d = |inCenter − inTarget|, unsigned, `PIXEL_WIDTH` bits. Order of operands does not matter.
- Square: s = d × d at full width, 2·`PIXEL_WIDTH` bits. s is then saturated to `E_WIDTH` bits: if s > 2^`E_WIDTH`−1, the value is 2^`E_WIDTH`−1 (16383 at defaults).
- Candidate: m = min(inE, sat(s)). On equality, either value is taken, since they are the same.
- Rising edge with `start`=1:
  - `Eout` ← m.
  - `Q` ← 1.
- Rising edge with `start`=0:
  - `Q` ← 0.
  - `Eout` holds its previous value. The final score stays stable after the chain drains and `detectCorner` falls.
- Reset (`rst_n`=0), asynchronous and taking effect immediately regardless of `clk`:
  - `Q` = 0, `Eout` = 0.
  - Both stay there while reset is held.
  - The first rising edge after `rst_n` rises updates normally.
- Inputs are sampled only at the rising edge. There is no internal state besides `Q` and `Eout`.
- Pure data-path block: no FSM, no handshake back-pressure. `start` is a level, not a pulse. Holding it high re-evaluates every cycle with the current inputs.

## Timing
- Latency is 1 cycle from `start`/data sampled to `Q`/`Eout` valid. `Eout` and `Q` change on the same edge.
- In a chain of N stages, the chain's final `Eout` is valid N edges after `start` first rises at stage 1, provided that stage 1 `start` stays high long enough to propagate. With N = 4, the result is valid 4 edges after `detectCorner` rises.
- Pixel inputs must be stable at each stage's sampling edge. The driver holds the window registers constant while the chain runs.
- Boundary values:
  - d = 0 gives `Eout` = 0.
  - d ≥ 128 at defaults (128² = 16384) saturates to 16383 before the min.
  - `inE` = 0 forces `Eout` = 0.
  - `inE` = 2^`E_WIDTH`−1 passes sat(s).
- If reset is asserted mid-chain, all stages clear at once and no stale token emerges afterwards.

## Test plan
- Reset: assert `rst_n`=0 with `start`=1 and arbitrary data → `Q`=0 and `Eout`=0 immediately, without waiting for a clock edge. Release reset → next edge updates.
- Basic: `start`=1, `inCenter`=100, `inTarget`=90, `inE`=10000 → after 1 edge, `Eout`=100 and `Q`=1. Swap center and target → same `Eout`=100.
- Saturation and min:
  - center 10, target 200 (s = 36100), `inE`=10000 → `Eout`=10000.
  - `inE`=16383 → `Eout`=16383.
- Zero difference: center = target = 55, `inE`=10000 → `Eout`=0.
- Hold: after `Eout`=100, drive `start`=0 and change all inputs → `Q`=0 and `Eout` stays 100 for 5 cycles.
- Four-stage chain: center 50, targets 60, 45, 80, 52, first `inE`=10000, single `start` rise on stage 1 held high:
  - Q1–Q4 rise on consecutive edges.
  - Final `Eout` = min(100, 25, 900, 4) = 4, valid on edge 4.
  - Repeat with one target = 50 → final `Eout`=0.
